// File: rtl/mem_bank_arbiter.sv
`default_nettype none
// mem_bank_arbiter: round-robin ownership arbiter for the shared memory bank register.
// Drives the bank register's ce/new_bank with a one-cycle switch before granting.
module mem_bank_arbiter #(
  parameter int WIDTH = 2,
  parameter int NREQ  = 2,
  localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_bank,
  input  logic [NREQ-1:0]         rel,
  output logic [NREQ-1:0]         gnt,
  output logic [OW-1:0]           owner,
  output logic                    busy,
  output logic                    bank_ce,
  output logic [WIDTH-1:0]        bank_new
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    GRANT  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [OW-1:0]     owner_n, rr, rr_n, win;
  logic [WIDTH-1:0]  tgt, tgt_n, cur_bank, cur_bank_n, bank_new_n;
  logic [NREQ-1:0]   gnt_n;
  logic              bank_ce_n, busy_n, found;

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Scan rr, rr+1, ... with explicit wrap so the index never reaches NREQ.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
  end

  always_comb begin
    state_n    = state;
    owner_n    = owner;
    tgt_n      = tgt;
    cur_bank_n = cur_bank;
    rr_n       = rr;
    bank_new_n = bank_new;
    case (state)
      IDLE: begin
        if (found) begin
          owner_n = win;
          tgt_n   = req_bank[int'(win)*WIDTH +: WIDTH];
          if (tgt_n != cur_bank) begin
            state_n    = SWITCH;
            bank_new_n = tgt_n;
          end else begin
            state_n = GRANT;
            rr_n    = next_idx(win);
          end
        end
      end
      SWITCH: begin
        state_n    = GRANT;
        cur_bank_n = tgt;
        rr_n       = next_idx(owner);
      end
      GRANT: begin
        if (rel[owner]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    bank_ce_n = (state_n == SWITCH);
    busy_n    = (state_n != IDLE);
    gnt_n     = '0;
    if (state_n == GRANT) gnt_n[owner_n] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      tgt      <= '0;
      cur_bank <= '0;
      rr       <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
      bank_ce  <= 1'b0;
      bank_new <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      tgt      <= tgt_n;
      cur_bank <= cur_bank_n;
      rr       <= rr_n;
      gnt      <= gnt_n;
      busy     <= busy_n;
      bank_ce  <= bank_ce_n;
      bank_new <= bank_new_n;
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_bank_arbiter.md
Name: mem_bank_arbiter

Overview:
Shares the single memory bank register between NREQ requesters, e.g. the CPU core and the program loader/DMA.
- Arbitrates bank-ownership requests round-robin.
- Sequences the bank register's ce/new_bank for a one-cycle switch.
- Holds the grant until the owner releases.
- Sits directly in front of the bank register and drives its ce and new_bank inputs.

Parameters:
WIDTH, 2, bank number width; must match the bank register.
NREQ, 2, number of requesters (2..8).
OW, $clog2(NREQ) with minimum 1, derived width of the owner index; not overridable.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req  input  NREQ  per-requester request for bank ownership; must be held until the matching gnt bit rises
req_bank  input  NREQ*WIDTH  packed requested bank; slice i = req_bank[i*WIDTH +: WIDTH]; sampled only when requester i wins
rel  input  NREQ  per-requester release pulse; honoured only from the current owner in GRANT
gnt  output  NREQ  one-hot grant; all zero outside GRANT
owner  output  OW  index of the current/last granted requester
busy  output  1  high in any state other than IDLE
bank_ce  output  1  to bank register ce
bank_new  output  WIDTH  to bank register new_bank

Behaviour:
Reset (async, immediate):
- State IDLE, gnt=0, owner=0, busy=0, bank_ce=0, bank_new=0.
- Internal cur_bank mirror=0, matching the bank register's reset value.
- Round-robin pointer rr=0, so requester 0 has highest priority.

FSM states: IDLE, SWITCH, GRANT. All outputs are registered.

IDLE:
- If any req bit is set, pick the winner w = first set bit scanning rr, rr+1, ... modulo NREQ.
- Latch w into owner and req_bank slice w into tgt.
- If tgt != cur_bank: go to SWITCH, with bank_ce=1 and bank_new=tgt registered for that cycle.
- If tgt == cur_bank: go straight to GRANT. No bank_ce pulse.
- No req: stay in IDLE.

SWITCH (exactly 1 cycle):
- bank_ce=1, bank_new=tgt.
- Next state GRANT; cur_bank<=tgt.
- The bank register output equals tgt from the first GRANT cycle.

GRANT:
- gnt[owner]=1; bank_ce=0; bank_new holds its last value.
- rr <= (owner+1) mod NREQ, updated on entry to GRANT.
- rel[owner]=1: next state IDLE, gnt clears on that edge.
- Other rel bits and all req changes are ignored.

Latency:
- Request to grant is 2 cycles when a switch is needed, 1 cycle when no switch is needed.
- Release to IDLE is 1 cycle.
- Release to the next grant is at least 2 cycles (one IDLE bubble is mandatory).

Boundary conditions:
- rel[owner] in the same cycle as other requests: go to IDLE first; arbitration happens in the IDLE cycle.
- Owner's own req still high at release: it is considered again, but with lowest priority because of rr.
- rel while not in GRANT: ignored.
- req bit dropped during SWITCH: switch still completes and GRANT is entered. This is a protocol violation; do not recover.
- Owner index wrap: rr wraps NREQ-1 -> 0.
- Non-power-of-two NREQ must never yield rr >= NREQ.
- Reset in SWITCH or GRANT: all outputs drop immediately. No partial switch is remembered; cur_bank=0.
- gnt is one-hot or zero in every cycle.
- bank_ce is high only in SWITCH.

Test Plan:
- Reset: assert rst mid-run -> gnt=00, bank_ce=0, bank_new=0, busy=0, owner=0 asynchronously, before the next clk edge.
- Switch path (WIDTH=2, NREQ=2), from reset:
  - req=01, req_bank[1:0]=2 in cycle 0 -> cycle 1 bank_ce=1, bank_new=2 -> cycle 2 gnt=01, bank register reads 2.
  - rel=01 -> gnt=00 next cycle.
- No-switch path: after the switch-path test, req=10, req_bank[3:2]=2 -> gnt=10 one cycle later; bank_ce stays 0 throughout.
- Round robin: from reset, req=11 with banks 1 and 3:
  - Order is gnt=01 with bank 1, release, then gnt=10 with bank 3.
  - Then req=11 again -> gnt=01 (rr wrapped).
- Release edge cases:
  - In GRANT with owner 0, rel=10 -> no effect.
  - rel=01 with req=10 same cycle -> one IDLE cycle, then SWITCH/GRANT to requester 1.
- Reset mid-SWITCH: rst during bank_ce=1 -> all outputs 0.
  - After reset, req=01 with bank 0 -> direct GRANT without bank_ce.
